// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with a baud tick generator, a TX FIFO and a frame FSM
module uart_tx_fifo_param #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 16,
    parameter int          AW         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic                 Tx_WR,
    input  logic                 Tx_EN,
    input  logic [2:0]           baud_select,
    input  logic [1:0]           parity_mode,
    output logic                 TxD,
    output logic                 Tx_BUSY,
    output logic                 Tx_FULL,
    output logic                 Tx_EMPTY,
    output logic [AW:0]          Tx_LEVEL,
    output logic                 Tx_OVF
);
    function automatic int unsigned div_of(input int unsigned rate);
        return (CLK_HZ + 8 * rate) / (16 * rate);
    endfunction

    localparam int unsigned DIV [8] = '{div_of(300), div_of(1200), div_of(4800), div_of(9600),
                                        div_of(19200), div_of(38400), div_of(57600), div_of(115200)};
    localparam int CW = $clog2(div_of(300) + 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          level_q, level_d;
    logic                 ovf_q;
    state_e               state_q;
    logic                 txd_q, busy_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q, par_bit_q;
    logic [2:0]           baud_q;
    logic [CW-1:0]        cnt_q, div_m1;
    logic [3:0]           sub_q, bit_q;
    logic                 full, empty, push, pop, tick, bit_end, last_stop;

    // FIFO status, baud tick and the pop/push decisions shared by FIFO and FSM
    always_comb begin
        full      = level_q == (AW+1)'(FIFO_DEPTH);
        empty     = level_q == '0;
        div_m1    = CW'(DIV[baud_q] - 1);
        tick      = state_q != IDLE && cnt_q == div_m1;
        bit_end   = tick && sub_q == 4'd15;
        last_stop = state_q == STOP && bit_end && bit_q == LAST_STOP;
        pop       = Tx_EN && !empty && (state_q == IDLE || last_stop);
        push      = Tx_WR && (!full || pop);
        level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // FIFO storage; a write while full and popping lands in the slot being freed
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= Tx_DATA;
    end

    // FIFO pointers, occupancy and the dropped-write pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= Tx_WR && full && !pop;
        end
    end

    // Frame sequencer: registered line and busy, divider and bit counters restart per frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            baud_q    <= '0;
            cnt_q     <= '0;
            sub_q     <= '0;
            bit_q     <= '0;
        end else if (!Tx_EN) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= '0;
        end else if (pop) begin
            state_q   <= START;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            shift_q   <= mem_q[rptr_q];
            baud_q    <= baud_select;
            par_en_q  <= ^parity_mode;
            par_bit_q <= ^mem_q[rptr_q] ^ parity_mode[1];
            cnt_q     <= '0;
            sub_q     <= '0;
            bit_q     <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) sub_q <= sub_q + 1'b1;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == LAST_DATA) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            txd_q   <= par_en_q ? par_bit_q : 1'b1;
                            bit_q   <= '0;
                        end else begin
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                    STOP: begin
                        if (bit_q == LAST_STOP) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign TxD      = txd_q;
    assign Tx_BUSY  = busy_q;
    assign Tx_FULL  = full;
    assign Tx_EMPTY = empty;
    assign Tx_LEVEL = level_q;
    assign Tx_OVF   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: scoreboard bench for the FIFO-fed UART transmitter
module tb_uart_tx_fifo_param;
    // 8 MHz clock gives DIV = 4 at 115200 (64 clk/bit), 52 at 9600 (832), 9 at 57600 (144)
    localparam int L7 = 64;
    localparam int L3 = 832;
    localparam int L6 = 144;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Tx_DATA = '0;
    logic       Tx_WR = 1'b0;
    logic       Tx_EN = 1'b0;
    logic [2:0] baud_select = 3'd7;
    logic [1:0] parity_mode = 2'b00;
    logic       TxD, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVF;
    logic [4:0] Tx_LEVEL;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          L;
        bit          b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;

    uart_tx_fifo_param #(.CLK_HZ(8_000_000)) dut (
        .clk(clk), .reset(rst_n), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .baud_select(baud_select), .parity_mode(parity_mode), .TxD(TxD), .Tx_BUSY(Tx_BUSY),
        .Tx_FULL(Tx_FULL), .Tx_EMPTY(Tx_EMPTY), .Tx_LEVEL(Tx_LEVEL), .Tx_OVF(Tx_OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int par, input int L, input bit b2b);
        exp_t e;
        e.bits = '0;
        for (int i = 0; i < 8; i++) e.bits[i+1] = d[i];
        e.n = 9;
        if (par >= 0) begin
            e.bits[9] = par[0];
            e.n = 10;
        end
        e.bits[e.n] = 1'b1;
        e.n++;
        e.L = L;
        e.b2b = b2b;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        Tx_DATA = d;
        Tx_WR = 1'b1;
        step();
        Tx_WR = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= budget), 0);
        step();
    endtask

    task automatic wait_q_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("pop_timeout", 32'(n >= budget), 0);
        step();
    endtask

    // Monitor: on each start bit take the next expected frame, sample every bit mid-cell
    initial begin : monitor
        exp_t e;
        bit   b2b;
        int   fidx = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && TxD === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit seen, no frame expected");
                    while (TxD === 1'b0) @(negedge clk);
                end else begin
                    mon_busy = 1'b1;
                    e = exp_q.pop_front();
                    do begin
                        for (int k = 0; k < e.n; k++) begin
                            repeat (k == 0 ? e.L / 2 : e.L) @(negedge clk);
                            chk($sformatf("frame%0d_bit%0d", fidx, k), {Tx_BUSY, TxD}, {1'b1, e.bits[k]});
                        end
                        repeat (e.L - e.L / 2) @(negedge clk);
                        b2b = exp_q.size() != 0 && exp_q[0].b2b;
                        if (b2b) begin
                            chk($sformatf("frame%0d_b2b_start", fidx), {Tx_BUSY, TxD}, 2'b10);
                            e = exp_q.pop_front();
                        end else begin
                            chk($sformatf("frame%0d_end_idle", fidx), {Tx_BUSY, TxD}, 2'b01);
                        end
                        fidx++;
                    end while (b2b);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int bad;
        logic [7:0] d;
        repeat (3) step();
        chk("rst_txd", TxD, 1);
        chk("rst_busy", Tx_BUSY, 0);
        chk("rst_empty", Tx_EMPTY, 1);
        chk("rst_full", Tx_FULL, 0);
        chk("rst_level", Tx_LEVEL, 0);
        chk("rst_ovf", Tx_OVF, 0);
        rst_n = 1'b1;
        Tx_EN = 1'b1;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ({TxD, Tx_BUSY, Tx_EMPTY, Tx_LEVEL} !== {1'b1, 1'b0, 1'b1, 5'd0}) bad++;
        end
        chk("idle_10k_bad_cycles", bad, 0);
        step();
        mon_en = 1'b1;

        // A5, no parity, 115200
        exp_q.push_back(mk(8'hA5, -1, L7, 0));
        wr(8'hA5);
        chk("lat_wr_txd", TxD, 1);
        chk("lat_wr_level", Tx_LEVEL, 1);
        step();
        chk("lat_start_txd", TxD, 0);
        chk("lat_start_busy", Tx_BUSY, 1);
        chk("lat_start_level", Tx_LEVEL, 0);
        drain(2000);

        // 07 even parity, then 07 odd parity back to back; parity change mid-frame ignored
        parity_mode = 2'b01;
        exp_q.push_back(mk(8'h07, 1, L7, 0));
        wr(8'h07);
        repeat (100) step();
        parity_mode = 2'b10;
        exp_q.push_back(mk(8'h07, 0, L7, 1));
        wr(8'h07);
        wait_q_empty(2000);
        parity_mode = 2'b00;
        drain(2000);

        // baud change mid-frame takes effect on the next frame only
        exp_q.push_back(mk(8'h3C, -1, L7, 0));
        exp_q.push_back(mk(8'hC3, -1, L3, 1));
        wr(8'h3C);
        wr(8'hC3);
        repeat (200) step();
        baud_select = 3'd3;
        wait_q_empty(2000);
        baud_select = 3'd6;
        exp_q.push_back(mk(8'h5A, -1, L6, 1));
        wr(8'h5A);
        drain(15000);
        baud_select = 3'd7;

        // fill with Tx_EN low, overflow, then write-while-full at the first pop
        Tx_EN = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 8'h11 + 8'h01);
            exp_q.push_back(mk(d, -1, L7, i != 0));
            wr(d);
        end
        chk("fill_full", Tx_FULL, 1);
        chk("fill_level", Tx_LEVEL, 16);
        chk("fill_empty", Tx_EMPTY, 0);
        chk("fill_ovf", Tx_OVF, 0);
        chk("fill_txd", TxD, 1);
        wr(8'hEE);
        chk("ovf_pulse", Tx_OVF, 1);
        chk("ovf_level", Tx_LEVEL, 16);
        step();
        chk("ovf_one_cycle", Tx_OVF, 0);
        Tx_EN = 1'b1;
        Tx_DATA = 8'h77;
        Tx_WR = 1'b1;
        exp_q.push_back(mk(8'h77, -1, L7, 1));
        step();
        Tx_WR = 1'b0;
        chk("fullpop_ovf", Tx_OVF, 0);
        chk("fullpop_level", Tx_LEVEL, 16);
        chk("fullpop_txd", TxD, 0);
        drain(13000);

        // Tx_EN abort mid-DATA, then asynchronous reset mid-frame
        mon_en = 1'b0;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        repeat (150) step();
        chk("abort_pre_level", Tx_LEVEL, 2);
        chk("abort_pre_busy", Tx_BUSY, 1);
        Tx_EN = 1'b0;
        step();
        chk("abort_txd", TxD, 1);
        chk("abort_busy", Tx_BUSY, 0);
        chk("abort_level", Tx_LEVEL, 2);
        Tx_EN = 1'b1;
        step();
        chk("restart_txd", TxD, 0);
        chk("restart_level", Tx_LEVEL, 1);
        repeat (100) step();
        #2 rst_n = 1'b0;
        #2;
        chk("async_rst_txd", TxD, 1);
        chk("async_rst_busy", Tx_BUSY, 0);
        chk("async_rst_empty", Tx_EMPTY, 1);
        chk("async_rst_full", Tx_FULL, 0);
        chk("async_rst_level", Tx_LEVEL, 0);
        chk("async_rst_ovf", Tx_OVF, 0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("post_rst_idle", {Tx_BUSY, TxD, Tx_EMPTY}, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
